mmc_mdc_seq: RTL and testbench

- Parametrised sequential LCM/GCD engine; successor to the fixed 32-bit repeated-addition LCM block.
- Adds W-bit generic width, runtime mode select (LCM by repeated addition, GCD by repeated subtraction), a start/busy/done handshake, zero-operand error and LCM overflow detection.
- Used as an arithmetic coprocessor behind a simple controller: one operation in flight at a time, one step per clock.

---
 rtl/mmc_mdc_seq_if.sv | 21 ++
 rtl/mmc_mdc_seq.sv | 111 +++++++++++
 tb/tb_mmc_mdc_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mmc_mdc_seq_if.sv
// mmc_mdc_seq_if: start/busy/done handshake and operand/result bus of the LCM/GCD engine.
// The iter signal exists only when MMC_ITER_CNT_EN is defined.
interface mmc_mdc_seq_if #(parameter int W = 32, parameter int CNT_W = 16);
  logic         start;
  logic         mode;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         busy;
  logic         done;
  logic [W-1:0] res;
  logic         err;
  logic         ovf;
`ifdef MMC_ITER_CNT_EN
  logic [CNT_W-1:0] iter;
  modport master (output start, mode, i_a, i_b, input busy, done, res, err, ovf, iter);
  modport slave (input start, mode, i_a, i_b, output busy, done, res, err, ovf, iter);
`else
  modport master (output start, mode, i_a, i_b, input busy, done, res, err, ovf);
  modport slave (input start, mode, i_a, i_b, output busy, done, res, err, ovf);
`endif
endinterface

// File: rtl/mmc_mdc_seq.sv
// mmc_mdc_seq: sequential LCM (repeated addition) / GCD (repeated subtraction) engine, one step per clock.
// Optional iteration counter output enabled by defining MMC_ITER_CNT_EN.
module mmc_mdc_seq #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  mmc_mdc_seq_if.slave  bus
);
  typedef enum logic {IDLE, RUN} st_t;
  st_t st_q, st_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, ba_q, ba_d, bb_q, bb_d, res_q, res_d;
  logic md_q, md_d, first_q, first_d, busy_q, busy_d, done_q, done_d, err_q, err_d, ovf_q, ovf_d;
  logic [W:0] sum_a, sum_b;
  logic zero, eq, lt, ovf_hit, fin;
`ifdef MMC_ITER_CNT_EN
  logic [CNT_W-1:0] iter_q, iter_d;
`endif
  assign sum_a   = {1'b0, a_q} + {1'b0, ba_q};
  assign sum_b   = {1'b0, b_q} + {1'b0, bb_q};
  assign zero    = first_q && (a_q == '0 || b_q == '0);
  assign eq      = a_q == b_q;
  assign lt      = a_q < b_q;
  assign ovf_hit = !md_q && (lt ? sum_a[W] : sum_b[W]);
  assign fin     = st_q == RUN && (zero || eq || ovf_hit);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ba_q    <= '0;
      bb_q    <= '0;
      res_q   <= '0;
      md_q    <= 1'b0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ba_q    <= ba_d;
      bb_q    <= bb_d;
      res_q   <= res_d;
      md_q    <= md_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end
  always_comb st_d = st_q == IDLE ? (bus.start ? RUN : IDLE) : (fin ? IDLE : RUN);
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    ba_d    = ba_q;
    bb_d    = bb_q;
    res_d   = res_q;
    md_d    = md_q;
    first_d = first_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ovf_d   = ovf_q;
    if (st_q == IDLE) begin
      if (bus.start) begin
        a_d     = bus.i_a;
        b_d     = bus.i_b;
        ba_d    = bus.i_a;
        bb_d    = bus.i_b;
        md_d    = bus.mode;
        first_d = 1'b1;
        busy_d  = 1'b1;
      end
    end else begin
      first_d = 1'b0;
      if (fin) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        err_d  = zero;
        ovf_d  = !zero && !eq;
        res_d  = zero ? (md_q ? a_q | b_q : '0) : (eq ? a_q : '0);
      end else if (!md_q) begin
        // Carry was already ruled out above, so the low W bits are exact.
        a_d = lt ? sum_a[W-1:0] : a_q;
        b_d = lt ? b_q : sum_b[W-1:0];
      end else begin
        a_d = lt ? a_q : a_q - b_q;
        b_d = lt ? b_q - a_q : b_q;
      end
    end
  end
`ifdef MMC_ITER_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) iter_q <= '0;
    else iter_q <= iter_d;
  end
  always_comb iter_d = (st_q == IDLE && bus.start) ? '0 :
                       (st_q == RUN && !fin && !(&iter_q)) ? iter_q + 1'b1 : iter_q;
  assign bus.iter = iter_q;
`endif
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;
  assign bus.err  = err_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_mmc_mdc_seq.sv
// tb_mmc_mdc_seq: directed checks of LCM/GCD engine at W=32 and W=8.
module tb_mmc_mdc_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  mmc_mdc_seq_if #(.W(32)) b32 ();
  mmc_mdc_seq_if #(.W(8)) b8 ();
  mmc_mdc_seq #(.W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  mmc_mdc_seq #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input bit sel, input bit s, input bit m, input logic [31:0] a, input logic [31:0] b);
    if (sel) begin
      b8.start = s; b8.mode = m; b8.i_a = a[7:0]; b8.i_b = b[7:0];
    end else begin
      b32.start = s; b32.mode = m; b32.i_a = a; b32.i_b = b;
    end
  endtask
  task automatic wait_done(input bit sel, output int n);
    n = 0;
    while (!(sel ? b8.done : b32.done) && n < 300) begin
      cyc();
      n++;
    end
  endtask
  task automatic op(input string tag, input bit sel, input bit m, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] er, input bit ee, input bit eo, input int lat);
    int n;
    drive(sel, 1'b1, m, a, b);
    cyc();
    drive(sel, 1'b0, m, a, b);
    wait_done(sel, n);
    chk({tag, ".lat"}, n, lat);
    chk({tag, ".res"}, sel ? {24'd0, b8.res} : b32.res, er);
    chk({tag, ".err"}, sel ? b8.err : b32.err, ee);
    chk({tag, ".ovf"}, sel ? b8.ovf : b32.ovf, eo);
    chk({tag, ".busy"}, sel ? b8.busy : b32.busy, 0);
    cyc();
    chk({tag, ".done_pulse"}, sel ? b8.done : b32.done, 0);
  endtask
  initial begin
    int n;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    cyc();
    cyc();
    chk("rst.busy", b32.busy, 0);
    chk("rst.done", b32.done, 0);
    chk("rst.res", b32.res, 0);
    chk("rst.err", b32.err, 0);
    chk("rst.ovf", b32.ovf, 0);
    chk("rst8.res", b8.res, 0);
    rst_n = 1'b1;
    cyc();
    op("lcm4_6", 0, 0, 4, 6, 12, 0, 0, 4);
`ifdef MMC_ITER_CNT_EN
    chk("lcm4_6.iter", b32.iter, 3);
`endif
    op("gcd12_18", 0, 1, 12, 18, 6, 0, 0, 3);
    op("gcd17_5", 0, 1, 17, 5, 1, 0, 0, 7);
    op("lcm0_9", 0, 0, 0, 9, 0, 1, 0, 1);
    op("gcd0_9", 0, 1, 0, 9, 9, 1, 0, 1);
    op("lcm5_5", 0, 0, 5, 5, 5, 0, 0, 1);
    op("lcm200_201", 1, 0, 200, 201, 0, 0, 1, 1);
    op("lcm15_17", 1, 0, 15, 17, 255, 0, 0, 31);
    op("gcd0_0", 1, 1, 0, 0, 0, 1, 0, 1);
    drive(0, 1, 0, 4, 6);
    cyc();
    chk("ign.busy", b32.busy, 1);
    drive(0, 0, 0, 4, 6);
    cyc();
    drive(0, 1, 0, 3, 5);
    cyc();
    drive(0, 0, 0, 3, 5);
    chk("ign.busy2", b32.busy, 1);
    wait_done(0, n);
    chk("ign.lat", n, 2);
    chk("ign.res", b32.res, 12);
    drive(0, 1, 1, 8, 8);
    cyc();
    drive(0, 0, 1, 8, 8);
    chk("b2b.done_low", b32.done, 0);
    chk("b2b.busy", b32.busy, 1);
    cyc();
    chk("b2b.done", b32.done, 1);
    chk("b2b.res", b32.res, 8);
    cyc();
    drive(0, 1, 0, 7, 11);
    cyc();
    drive(0, 0, 0, 7, 11);
    cyc();
    cyc();
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mrst.busy", b32.busy, 0);
    chk("mrst.done", b32.done, 0);
    chk("mrst.res", b32.res, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n += b32.done;
    end
    chk("mrst.no_done", n, 0);
    op("lcm7_11", 0, 0, 7, 11, 77, 0, 0, 17);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
